// File: rtl/axis_pkt_fifo_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface : axis_pkt_fifo_if                                                |
// | AXI-Stream handshake bundle (tdata/tlast/tvalid/tready) with modports.      |
// | Revision  : 1.0                                                             |
// +----------------------------------------------------------------------------+
interface axis_pkt_fifo_if #(
    parameter int DATA_WIDTH = 16
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tlast;
    logic                  tready;

    modport master (output tdata, output tvalid, output tlast, input  tready);
    modport slave  (input  tdata, input  tvalid, input  tlast, output tready);
endinterface
`default_nettype wire

// File: rtl/axis_pkt_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : axis_pkt_fifo                                                   |
// | Single-clock AXI-Stream FIFO with level, almost-full and packet count.      |
// | Define AXIS_FIFO_PKT_MODE_EN for store-and-forward release of packets.      |
// | Revision  : 1.0                                                             |
// +----------------------------------------------------------------------------+
module axis_pkt_fifo #(
    parameter int DATA_WIDTH   = 16,
    parameter int DEPTH        = 2048,
    parameter int AFULL_THRESH = DEPTH - 4
) (
    input  wire logic                      clk,
    input  wire logic                      reset,
    axis_pkt_fifo_if.slave                 s_axis,
    axis_pkt_fifo_if.master                m_axis,
    output logic [$clog2(DEPTH):0]         level,
    output logic                           almost_full,
    output logic [$clog2(DEPTH):0]         pkt_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] AFULL_LVL = (AW+1)'(AFULL_THRESH);

    logic [DATA_WIDTH:0] mem [DEPTH];

    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0] level_q, level_d;
    logic [AW:0] pkt_cnt_q, pkt_cnt_d;

    logic                full;
    logic                empty;
    logic                s_ready;
    logic                m_valid;
    logic                wr_fire;
    logic                rd_fire;
    logic [DATA_WIDTH:0] rd_word;

    always_comb begin
        full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        empty   = (wr_ptr_q == rd_ptr_q);
        rd_word = mem[rd_ptr_q[AW-1:0]];
        // tready is gated by reset so the producer sees 0 throughout an asserted reset.
        s_ready = reset && !full;
`ifdef AXIS_FIFO_PKT_MODE_EN
        // Full with no complete packet would deadlock; let data cut through until space frees.
        m_valid = !empty && ((pkt_cnt_q != '0) || full);
`else
        m_valid = !empty;
`endif
        wr_fire = s_axis.tvalid && s_ready;
        rd_fire = m_valid && m_axis.tready;
    end

    assign s_axis.tready = s_ready;
    assign m_axis.tvalid = m_valid;
    assign m_axis.tdata  = rd_word[DATA_WIDTH-1:0];
    assign m_axis.tlast  = rd_word[DATA_WIDTH];

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        level_d   = level_q;
        pkt_cnt_d = pkt_cnt_q;
        if (wr_fire) wr_ptr_d = wr_ptr_q + 1'b1;
        if (rd_fire) rd_ptr_d = rd_ptr_q + 1'b1;
        case ({wr_fire, rd_fire})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
        case ({wr_fire && s_axis.tlast, rd_fire && rd_word[DATA_WIDTH]})
            2'b10:   pkt_cnt_d = pkt_cnt_q + 1'b1;
            2'b01:   pkt_cnt_d = pkt_cnt_q - 1'b1;
            default: pkt_cnt_d = pkt_cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            pkt_cnt_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            pkt_cnt_q <= pkt_cnt_d;
        end
    end

    // Storage is deliberately not reset; stale words are unreachable once pointers clear.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[wr_ptr_q[AW-1:0]] <= {s_axis.tlast, s_axis.tdata};
        end
    end

    assign level       = level_q;
    assign pkt_count   = pkt_cnt_q;
    assign almost_full = (level_q >= AFULL_LVL);

endmodule
`default_nettype wire

// File: tb/tb_axis_pkt_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : tb_axis_pkt_fifo                                                |
// | Directed vector bench for axis_pkt_fifo (DEPTH=16, DATA_WIDTH=16).          |
// | Revision  : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_axis_pkt_fifo;

`ifdef AXIS_FIFO_PKT_MODE_EN
    localparam bit PKT = 1'b1;
`else
    localparam bit PKT = 1'b0;
`endif
    localparam bit NP = !PKT;

    logic       clk;
    logic       reset;
    logic [4:0] level;
    logic       almost_full;
    logic [4:0] pkt_count;

    axis_pkt_fifo_if #(.DATA_WIDTH(16)) s_if ();
    axis_pkt_fifo_if #(.DATA_WIDTH(16)) m_if ();

    axis_pkt_fifo #(
        .DATA_WIDTH  (16),
        .DEPTH       (16),
        .AFULL_THRESH(12)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .s_axis     (s_if.slave),
        .m_axis     (m_if.master),
        .level      (level),
        .almost_full(almost_full),
        .pkt_count  (pkt_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wv;
        logic [15:0] wd;
        logic        wl;
        logic        rr;
        logic [4:0]  e_level;
        logic        e_mv;
        logic [15:0] e_md;
        logic        e_ml;
        logic        e_sr;
        logic        e_af;
        logic [4:0]  e_pkt;
    } vec_t;

    vec_t vq[$];
    int   n_pass;
    int   n_total;

    task automatic add(input logic wv, input logic [15:0] wd, input logic wl, input logic rr,
                       input logic [4:0] lv, input logic mv, input logic [15:0] md,
                       input logic ml, input logic sr, input logic af, input logic [4:0] pk);
        vec_t v;
        v.wv = wv; v.wd = wd; v.wl = wl; v.rr = rr;
        v.e_level = lv; v.e_mv = mv; v.e_md = md; v.e_ml = ml;
        v.e_sr = sr; v.e_af = af; v.e_pkt = pk;
        vq.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    endtask

    // Inputs change just after the falling edge; outputs are sampled 1ns later.
    task automatic drive(input logic wv, input logic [15:0] wd, input logic wl, input logic rr);
        @(negedge clk);
        s_if.tvalid = wv;
        s_if.tdata  = wd;
        s_if.tlast  = wl;
        m_if.tready = rr;
        #1;
    endtask

    initial begin
        n_pass = 0;
        n_total = 0;
        reset = 1'b0;
        s_if.tvalid = 1'b0;
        s_if.tdata  = '0;
        s_if.tlast  = 1'b0;
        m_if.tready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_level", level, 0);
        chk("rst_pkt", pkt_count, 0);
        chk("rst_mvalid", m_if.tvalid, 0);
        chk("rst_sready", s_if.tready, 0);
        chk("rst_afull", almost_full, 0);
        @(negedge clk);
        reset = 1'b1;

        // Basic ordering (tlast on word 5), then two 3-word packets.
        add(1, 16'h0001, 0, 0, 0, 0,  16'h0000, 0, 1, 0, 0);
        add(1, 16'h0002, 0, 0, 1, NP, 16'h0001, 0, 1, 0, 0);
        add(1, 16'h0003, 0, 0, 2, NP, 16'h0001, 0, 1, 0, 0);
        add(1, 16'h0004, 0, 0, 3, NP, 16'h0001, 0, 1, 0, 0);
        add(1, 16'h0005, 1, 0, 4, NP, 16'h0001, 0, 1, 0, 0);
        add(0, 16'h0000, 0, 1, 5, 1,  16'h0001, 0, 1, 0, 1);
        add(0, 16'h0000, 0, 1, 4, 1,  16'h0002, 0, 1, 0, 1);
        add(0, 16'h0000, 0, 1, 3, 1,  16'h0003, 0, 1, 0, 1);
        add(0, 16'h0000, 0, 1, 2, 1,  16'h0004, 0, 1, 0, 1);
        add(0, 16'h0000, 0, 1, 1, 1,  16'h0005, 1, 1, 0, 1);
        add(0, 16'h0000, 0, 0, 0, 0,  16'h0000, 0, 1, 0, 0);
        add(1, 16'h00A1, 0, 0, 0, 0,  16'h0000, 0, 1, 0, 0);
        add(1, 16'h00A2, 0, 0, 1, NP, 16'h00A1, 0, 1, 0, 0);
        add(1, 16'h00A3, 1, 0, 2, NP, 16'h00A1, 0, 1, 0, 0);
        add(1, 16'h00B1, 0, 0, 3, 1,  16'h00A1, 0, 1, 0, 1);
        add(1, 16'h00B2, 0, 0, 4, 1,  16'h00A1, 0, 1, 0, 1);
        add(1, 16'h00B3, 1, 0, 5, 1,  16'h00A1, 0, 1, 0, 1);
        add(0, 16'h0000, 0, 1, 6, 1,  16'h00A1, 0, 1, 0, 2);
        add(0, 16'h0000, 0, 1, 5, 1,  16'h00A2, 0, 1, 0, 2);
        add(0, 16'h0000, 0, 1, 4, 1,  16'h00A3, 1, 1, 0, 2);
        add(0, 16'h0000, 0, 1, 3, 1,  16'h00B1, 0, 1, 0, 1);
        add(0, 16'h0000, 0, 1, 2, 1,  16'h00B2, 0, 1, 0, 1);
        add(0, 16'h0000, 0, 1, 1, 1,  16'h00B3, 1, 1, 0, 1);
        add(0, 16'h0000, 0, 0, 0, 0,  16'h0000, 0, 1, 0, 0);

        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].wv, vq[i].wd, vq[i].wl, vq[i].rr);
            chk($sformatf("v%0d_level", i), level, vq[i].e_level);
            chk($sformatf("v%0d_mvalid", i), m_if.tvalid, vq[i].e_mv);
            chk($sformatf("v%0d_sready", i), s_if.tready, vq[i].e_sr);
            chk($sformatf("v%0d_afull", i), almost_full, vq[i].e_af);
            chk($sformatf("v%0d_pkt", i), pkt_count, vq[i].e_pkt);
            if (vq[i].e_mv) begin
                chk($sformatf("v%0d_mdata", i), m_if.tdata, vq[i].e_md);
                chk($sformatf("v%0d_mlast", i), m_if.tlast, vq[i].e_ml);
            end
        end

        // Fill to full, hold a 17th word, one read lets it in.
        for (int i = 0; i < 16; i++) begin
            drive(1, 16'h0100 + 16'(i), 0, 0);
            chk("full_sready", s_if.tready, 1);
            chk("full_level", level, 32'(i));
            chk("full_afull", almost_full, (i >= 12) ? 1 : 0);
        end
        drive(1, 16'h01FF, 1, 1);
        chk("held_sready", s_if.tready, 0);
        chk("held_level", level, 16);
        chk("held_afull", almost_full, 1);
        chk("held_mvalid", m_if.tvalid, 1);
        chk("held_mdata", m_if.tdata, 16'h0100);
        drive(1, 16'h01FF, 1, 0);
        chk("freed_sready", s_if.tready, 1);
        chk("freed_level", level, 15);
        drive(0, 16'h0000, 0, 0);
        chk("refull_level", level, 16);
        chk("refull_sready", s_if.tready, 0);
        chk("refull_pkt", pkt_count, 1);
        for (int i = 0; i < 16; i++) begin
            drive(0, 16'h0000, 0, 1);
            chk("drain_mvalid", m_if.tvalid, 1);
            chk("drain_mdata", m_if.tdata, (i < 15) ? (32'h0101 + 32'(i)) : 32'h01FF);
            chk("drain_mlast", m_if.tlast, (i == 15) ? 1 : 0);
        end
        drive(0, 16'h0000, 0, 0);
        chk("drained_level", level, 0);
        chk("drained_mvalid", m_if.tvalid, 0);

        // Streaming write+read across two pointer wraps.
        drive(1, 16'h0300, 1, 1);
        chk("stream0_mvalid", m_if.tvalid, 0);
        for (int k = 1; k < 40; k++) begin
            drive(1, 16'h0300 + 16'(k), 1, 1);
            chk("stream_level", level, 1);
            chk("stream_mvalid", m_if.tvalid, 1);
            chk("stream_mdata", m_if.tdata, 32'h0300 + 32'(k - 1));
        end
        drive(0, 16'h0000, 0, 1);
        chk("stream_tail_data", m_if.tdata, 16'h0327);
        drive(0, 16'h0000, 0, 0);
        chk("stream_end_level", level, 0);

        // Asynchronous reset mid-packet.
        for (int i = 0; i < 7; i++) drive(1, 16'h0500 + 16'(i), (i == 2) ? 1'b1 : 1'b0, 0);
        drive(0, 16'h0000, 0, 0);
        chk("pre_rst_level", level, 7);
        chk("pre_rst_pkt", pkt_count, 1);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_level", level, 0);
        chk("arst_pkt", pkt_count, 0);
        chk("arst_mvalid", m_if.tvalid, 0);
        chk("arst_sready", s_if.tready, 0);
        chk("arst_afull", almost_full, 0);
        drive(0, 16'h0000, 0, 0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rel_sready", s_if.tready, 1);
        chk("rel_mvalid", m_if.tvalid, 0);
        drive(1, 16'h5A5A, 1, 0);
        drive(0, 16'h0000, 0, 0);
        chk("post_rst_level", level, 1);
        chk("post_rst_mvalid", m_if.tvalid, 1);
        chk("post_rst_mdata", m_if.tdata, 16'h5A5A);
        chk("post_rst_mlast", m_if.tlast, 1);
        drive(0, 16'h0000, 0, 1);
        drive(0, 16'h0000, 0, 0);
        chk("post_rst_empty", level, 0);

`ifdef AXIS_FIFO_PKT_MODE_EN
        for (int i = 0; i < 4; i++) drive(1, 16'h0600 + 16'(i), 0, 0);
        drive(0, 16'h0000, 0, 0);
        chk("pm_hold_mvalid", m_if.tvalid, 0);
        chk("pm_hold_level", level, 4);
        drive(1, 16'h0604, 1, 0);
        drive(0, 16'h0000, 0, 0);
        chk("pm_rel_mvalid", m_if.tvalid, 1);
        chk("pm_rel_pkt", pkt_count, 1);
        for (int i = 0; i < 5; i++) begin
            drive(0, 16'h0000, 0, 1);
            chk("pm_drain_mdata", m_if.tdata, 32'h0600 + 32'(i));
        end
        drive(0, 16'h0000, 0, 0);
        chk("pm_drained_level", level, 0);
        for (int i = 0; i < 16; i++) begin
            drive(1, 16'h0700 + 16'(i), 0, 0);
            if (i == 15) chk("pm_l15_mvalid", m_if.tvalid, 0);
        end
        drive(0, 16'h0000, 0, 0);
        chk("pm_esc_level", level, 16);
        chk("pm_esc_pkt", pkt_count, 0);
        chk("pm_esc_mvalid", m_if.tvalid, 1);
        chk("pm_esc_mdata", m_if.tdata, 16'h0700);
`else
        for (int i = 0; i < 4; i++) drive(1, 16'h0600 + 16'(i), 0, 0);
        drive(0, 16'h0000, 0, 0);
        chk("ct_mvalid", m_if.tvalid, 1);
        chk("ct_level", level, 4);
        chk("ct_pkt", pkt_count, 0);
        chk("ct_mdata", m_if.tdata, 16'h0600);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
